// File: rtl/bcd_to_binary_converter.sv
// Purpose : packed-BCD to unsigned binary via reverse double-dabble, one shift/correct step per clock.
// Latency : out_valid rises 4*DIGITS cycles after the accepting edge (1 cycle for a rejected word with BCD_CHECK_EN).
// Backpr. : valid/ready both sides; busy while converting or holding a result, result held until out_ready.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake, bcd_in sampled only on the accepting edge
//   bcd_in                packed BCD, nibble 0 = ones
//   out_valid / out_ready output handshake, bin_out/err stable while out_valid
//   bin_out, err          converted value, illegal-digit flag
//
// Optional feature macro: BCD_CHECK_EN
//   defined   : a word with any nibble > 9 bypasses the conversion and completes one
//               cycle after accept with bin_out=0, err=1.
//   undefined : no digit check, err tied low, illegal digits run through the normal path.

module bcd_to_binary_converter #(
   parameter int DIGITS = 3,
   parameter int BIN_W  = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int WORK_W = 2 * BCD_W;
   localparam int STEPS  = BCD_W;
   localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [WORK_W-1:0]   work_q;
   logic [WORK_W-1:0]   work_step;
   logic [CNT_W-1:0]    cnt_q;
   logic [BIN_W-1:0]    bin_q;
   logic                accept;
   logic                last_step;
   logic                conv_abort;
   logic [BCD_W-1:0]    work_lo;
   logic [BIN_W-1:0]    result;

   // One reverse double-dabble step: shift the whole work register right, then any
   // BCD nibble in the upper half that now reads >= 8 had a "10" shifted into it from
   // the digit above, which is worth 5 (not 8) at this weight, so take 3 off.
   function automatic logic [WORK_W-1:0] dabble_step(input logic [WORK_W-1:0] w);
      logic [WORK_W-1:0] s;
      s = w >> 1;
      for (int d = 0; d < DIGITS; d++) begin
         if (s[BCD_W + 4*d + 3]) begin
            s[BCD_W + 4*d +: 4] = s[BCD_W + 4*d +: 4] - 4'd3;
         end
      end
      return s;
   endfunction

   assign work_step = dabble_step(work_q);
   assign last_step = (cnt_q == LAST_STEP);

   // After the final step the binary value sits in the lower half; with a legal
   // BIN_W the bits above BIN_W are always zero and are dropped here.
   assign work_lo = work_step[BCD_W-1:0];
   assign result  = BIN_W'(work_lo);

   assign accept  = in_valid & in_ready;

`ifdef BCD_CHECK_EN
   logic bad_q;
   logic bad_in;
   logic err_q;

   // A nibble is illegal when it is 10..15: bit 3 set together with bit 2 or bit 1.
   function automatic logic any_illegal(input logic [BCD_W-1:0] b);
      logic hit;
      hit = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (b[4*d + 3] && (b[4*d + 2] || b[4*d + 1])) begin
            hit = 1'b1;
         end
      end
      return hit;
   endfunction

   assign bad_in     = any_illegal(bcd_in);
   assign conv_abort = (state_q == CONV) && bad_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bad_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         if (accept) begin
            bad_q <= bad_in;
         end
         if (state_q == CONV) begin
            if (bad_q) begin
               err_q <= 1'b1;
            end else if (last_step) begin
               err_q <= 1'b0;
            end
         end
      end
   end

   assign err = err_q;
`else
   assign conv_abort = 1'b0;
   assign err        = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. DONE never accepts a new word, which leaves one idle
   // cycle between results.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CONV;
            end
         end
         CONV: begin
            if (conv_abort || last_step) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE:    in_ready  = 1'b1;
         DONE:    out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Datapath: work register, step counter and the held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
         cnt_q  <= '0;
         bin_q  <= '0;
      end else begin
         if (accept) begin
            work_q <= {bcd_in, {BCD_W{1'b0}}};
            cnt_q  <= '0;
         end else if (conv_abort) begin
            bin_q  <= '0;
         end else if (state_q == CONV) begin
            work_q <= work_step;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (last_step) begin
               bin_q <= result;
            end
         end
      end
   end

   assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_converter.sv
module tb_bcd_to_binary_converter;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] bcd_in;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  bin_out;
   logic        err;

   int checks;
   int errors;

   bcd_to_binary_converter #(.DIGITS(3), .BIN_W(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bcd_in    (bcd_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin_out   (bin_out),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Offer a word, wait for acceptance, then wait for the result and check it.
   // Leaves the caller one cycle into DONE; the caller does the output handshake.
   task automatic run_word(input logic [11:0] w, input logic [9:0] exp_bin,
                           input logic chk_bin, input logic exp_err, input string tag);
      int n;
      bcd_in   = w;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_accept"}, in_ready, 1);
      tick();
      in_valid = 1'b0;
      chk({tag, "_busy"}, in_ready, 0);
      n = 0;
      while (!out_valid && n < 100) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 12);
      if (chk_bin) chk({tag, "_bin"}, bin_out, exp_bin);
      chk({tag, "_err"}, err, exp_err);
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bcd_in    = 12'h000;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_bin_out",   bin_out,   0);
      chk("rst_err",       err,       0);

      // 999 -> 999, latency 12
      out_ready = 1'b1;
      run_word(12'h999, 10'd999, 1'b1, 1'b0, "w999");
      chk("w999_in_ready_done", in_ready, 0);
      tick();
      chk("w999_hs_out_valid", out_valid, 0);
      chk("w999_hs_in_ready",  in_ready,  1);

      // 000 then 255 with the next word held on the input throughout
      bcd_in   = 12'h000;
      in_valid = 1'b1;
      tick();
      bcd_in = 12'h255;
      repeat (11) tick();
      chk("b2b_lat11_out_valid", out_valid, 0);
      chk("b2b_lat11_in_ready",  in_ready,  0);
      tick();
      chk("b2b_w0_out_valid", out_valid, 1);
      chk("b2b_w0_bin",       bin_out,   0);
      chk("b2b_w0_in_ready",  in_ready,  0);
      tick();
      chk("b2b_hs_out_valid", out_valid, 0);
      chk("b2b_hs_in_ready",  in_ready,  1);
      tick();
      in_valid = 1'b0;
      chk("b2b_w1_busy", in_ready, 0);
      repeat (11) tick();
      chk("b2b_w1_lat11", out_valid, 0);
      tick();
      chk("b2b_w1_out_valid", out_valid, 1);
      chk("b2b_w1_bin",       bin_out,   255);
      tick();

      // Full legal sweep against the decimal value
      for (int i = 0; i < 1000; i++) begin
         logic [11:0] w;
         w = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
         run_word(w, 10'(i), 1'b1, 1'b0, "sweep");
         tick();
      end

      // Backpressure: result held, in_valid ignored
      out_ready = 1'b0;
      run_word(12'h047, 10'd47, 1'b1, 1'b0, "w047");
      for (int k = 0; k < 20; k++) begin
         in_valid = k[0];
         bcd_in   = 12'h123;
         tick();
         chk("bp_out_valid", out_valid, 1);
         chk("bp_bin",       bin_out,   47);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_rel_out_valid", out_valid, 0);
      chk("bp_rel_in_ready",  in_ready,  1);
      tick();
      chk("bp_idle_in_ready", in_ready, 1);
      chk("bp_retained_bin",  bin_out,  47);

`ifdef BCD_CHECK_EN
      // Illegal digit rejected one cycle after accept
      bcd_in   = 12'h9A1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("ill_busy", in_ready, 0);
      tick();
      chk("ill_out_valid", out_valid, 1);
      chk("ill_err",       err,       1);
      chk("ill_bin",       bin_out,   0);
      tick();
      chk("ill_hs_in_ready", in_ready, 1);
      run_word(12'h123, 10'd123, 1'b1, 1'b0, "w123");
      tick();
`else
      run_word(12'h9A1, 10'd0, 1'b0, 1'b0, "ill_nochk");
      tick();
`endif

      // Reset during conversion
      bcd_in   = 12'h876;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready",  in_ready,  1);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      chk("post_rst_in_ready", in_ready, 1);
      chk("post_rst_bin",      bin_out,  0);
      begin
         int seen;
         seen = 0;
         repeat (15) begin
            tick();
            if (out_valid) seen++;
         end
         chk("post_rst_no_stale", seen, 0);
      end
      run_word(12'h321, 10'd321, 1'b1, 1'b0, "w321");
      tick();
      chk("w321_hs_out_valid", out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
